// File: rtl/zeroheti_apb_pkg.sv
// ----------------------------------------------------------------------------
// zeroheti_apb_pkg
// Shared types and constants for the OBI-to-APB4 bridge.
//   bridge_state_e : bridge FSM states (IDLE -> SETUP -> ACCESS -> RESP)
//   PPROT_DEFAULT  : protection attribute driven on every APB transfer
//   BusDataWidth   : the only supported data width
//   StrbWidth      : byte-enable / strobe width derived from BusDataWidth
// ----------------------------------------------------------------------------
package zeroheti_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bridge_state_e;

    // Normal, secure, data access.
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    localparam int BusDataWidth = 32;
    localparam int StrbWidth    = BusDataWidth / 8;

endpackage

// File: rtl/zeroheti_timeout_cnt.sv
// ----------------------------------------------------------------------------
// zeroheti_timeout_cnt
// Saturating cycle counter used to bound the wait on PREADY.
//   clk_i     : clock
//   rst_i     : synchronous reset, active-high
//   clear_i   : synchronous clear back to zero
//   en_i      : count one cycle
//   expired_o : count has reached Limit-1 (never asserted when Limit == 0)
// ----------------------------------------------------------------------------
module zeroheti_timeout_cnt #(
    parameter int Limit = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CntWidth = (Limit == 0) ? 1 : $clog2(Limit + 1);

    logic [CntWidth-1:0] count_q;

    // Counter holds at its all-ones value instead of wrapping, so a long
    // stall can never look like a fresh transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != {CntWidth{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    // A zero limit disables the timeout entirely.
    generate
        if (Limit == 0) begin : g_disabled
            assign expired_o = 1'b0;
        end else begin : g_enabled
            assign expired_o = (count_q == CntWidth'(Limit - 1));
        end
    endgenerate

endmodule

// File: rtl/zeroheti_obi_apb_bridge.sv
// ----------------------------------------------------------------------------
// zeroheti_obi_apb_bridge
// OBI subordinate to APB4 manager bridge; one transaction in flight at a time.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   obi_req_i / obi_gnt_o   : OBI address phase handshake (grant only in IDLE)
//   obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i, obi_aid_i : request fields
//   obi_rvalid_o / obi_rready_i : OBI response handshake
//   obi_rdata_o, obi_err_o, obi_rid_o : response fields, stable while rvalid
//   paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, pprot_o : APB out
//   pready_i, prdata_i, pslverr_i : APB completer response
// ----------------------------------------------------------------------------
module zeroheti_obi_apb_bridge
    import zeroheti_apb_pkg::*;
#(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int IdWidth       = 1,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [StrbWidth-1:0] obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    input  logic [IdWidth-1:0]   obi_aid_i,
    output logic                 obi_rvalid_o,
    input  logic                 obi_rready_i,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 obi_err_o,
    output logic [IdWidth-1:0]   obi_rid_o,
    output logic [AddrWidth-1:0] paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DataWidth-1:0] pwdata_o,
    output logic [StrbWidth-1:0] pstrb_o,
    output logic [2:0]           pprot_o,
    input  logic                 pready_i,
    input  logic [DataWidth-1:0] prdata_i,
    input  logic                 pslverr_i
);

    bridge_state_e state_q;
    logic          timeout_hit;

    assign obi_gnt_o = obi_req_i && (state_q == IDLE);
    assign pprot_o   = PPROT_DEFAULT;

    // Counts only stalled ACCESS cycles; held at zero in every other state,
    // which also covers clearing it on the RESP -> IDLE hand-off.
    zeroheti_timeout_cnt #(
        .Limit (TimeoutCycles)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q != ACCESS),
        .en_i      ((state_q == ACCESS) && !pready_i),
        .expired_o (timeout_hit)
    );

    // Bridge FSM. All APB and OBI response outputs are registered here, so
    // the APB address/control captured at grant stay untouched until the
    // next grant. PREADY is tested before the timeout so it wins a tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            obi_rvalid_o <= 1'b0;
            obi_err_o    <= 1'b0;
            obi_rdata_o  <= '0;
            obi_rid_o    <= '0;
            paddr_o      <= '0;
            pwrite_o     <= 1'b0;
            pwdata_o     <= '0;
            pstrb_o      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (obi_gnt_o) begin
                        paddr_o   <= obi_addr_i;
                        pwrite_o  <= obi_we_i;
                        pwdata_o  <= obi_wdata_i;
                        pstrb_o   <= obi_we_i ? obi_be_i : '0;
                        obi_rid_o <= obi_aid_i;
                        psel_o    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        obi_rdata_o  <= pwrite_o ? '0 : prdata_i;
                        obi_err_o    <= pslverr_i;
                        psel_o       <= 1'b0;
                        penable_o    <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        state_q      <= RESP;
                    end else if (timeout_hit) begin
                        obi_rdata_o  <= '0;
                        obi_err_o    <= 1'b1;
                        psel_o       <= 1'b0;
                        penable_o    <= 1'b0;
                        obi_rvalid_o <= 1'b1;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (obi_rready_i) begin
                        obi_rvalid_o <= 1'b0;
                        obi_err_o    <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zeroheti_obi_apb_bridge.sv
// ----------------------------------------------------------------------------
// tb_zeroheti_obi_apb_bridge
// Directed bench for the OBI-to-APB4 bridge, built with a 4-cycle timeout so
// both the timeout path and the PREADY-beats-timeout tie are reachable.
// ----------------------------------------------------------------------------
module tb_zeroheti_obi_apb_bridge;

    localparam int TimeoutCycles = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic [0:0]  obi_aid_i;
    logic        obi_rvalid_o;
    logic        obi_rready_i;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;
    logic [0:0]  obi_rid_o;
    logic [31:0] paddr_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        aid;
        logic [3:0]  waits;
        logic        timeout;
        logic [31:0] prdata;
        logic        pslverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_strb;
    } vector_t;

    vector_t vectors [5];

    zeroheti_obi_apb_bridge #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .IdWidth       (1),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_aid_i    (obi_aid_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rready_i (obi_rready_i),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o),
        .obi_rid_o    (obi_rid_o),
        .paddr_o      (paddr_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .pwdata_o     (pwdata_o),
        .pstrb_o      (pstrb_o),
        .pprot_o      (pprot_o),
        .pready_i     (pready_i),
        .prdata_i     (prdata_i),
        .pslverr_i    (pslverr_i)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    // One comparison: bump the check count, and report and count a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive the OBI request fields for one vector.
    task automatic applyStimulus(input vector_t v, input logic req);
        obi_req_i   = req;
        obi_we_i    = v.we;
        obi_addr_i  = v.addr;
        obi_be_i    = v.be;
        obi_wdata_i = v.wdata;
        obi_aid_i   = v.aid;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    // Runs one complete transaction, checking every cycle from grant to
    // response. Inputs change 1 ns after an edge, outputs are sampled 2 ns
    // after the edge.
    task automatic runTransaction(input vector_t v, input int idx);
        int access_cycles;
        access_cycles = v.timeout ? TimeoutCycles : (int'(v.waits) + 1);
        applyStimulus(v, 1'b1);
        #1;
        checkOutput($sformatf("v%0d gnt", idx), 32'(obi_gnt_o), 32'd1);
        nextCycle();
        obi_req_i = 1'b0;
        #1;
        checkOutput($sformatf("v%0d setup psel", idx), 32'(psel_o), 32'd1);
        checkOutput($sformatf("v%0d setup penable", idx), 32'(penable_o), 32'd0);
        checkOutput($sformatf("v%0d setup pwrite", idx), 32'(pwrite_o), 32'(v.we));
        for (int i = 0; i < access_cycles; i++) begin
            nextCycle();
            pready_i  = !v.timeout && (i == access_cycles - 1);
            prdata_i  = v.prdata;
            pslverr_i = v.pslverr;
            #1;
            checkOutput($sformatf("v%0d access%0d psel", idx, i), 32'(psel_o), 32'd1);
            checkOutput($sformatf("v%0d access%0d penable", idx, i), 32'(penable_o), 32'd1);
            checkOutput($sformatf("v%0d access%0d paddr", idx, i), paddr_o, v.addr);
            checkOutput($sformatf("v%0d access%0d pstrb", idx, i), 32'(pstrb_o), 32'(v.exp_strb));
            if (v.we) begin
                checkOutput($sformatf("v%0d access%0d pwdata", idx, i), pwdata_o, v.wdata);
            end
            checkOutput($sformatf("v%0d access%0d rvalid", idx, i), 32'(obi_rvalid_o), 32'd0);
        end
        nextCycle();
        pready_i  = 1'b0;
        prdata_i  = 32'h0;
        pslverr_i = 1'b0;
        #1;
        checkOutput($sformatf("v%0d resp psel", idx), 32'(psel_o), 32'd0);
        checkOutput($sformatf("v%0d resp rvalid", idx), 32'(obi_rvalid_o), 32'd1);
        checkOutput($sformatf("v%0d resp rdata", idx), obi_rdata_o, v.exp_rdata);
        checkOutput($sformatf("v%0d resp err", idx), 32'(obi_err_o), 32'(v.exp_err));
        checkOutput($sformatf("v%0d resp rid", idx), 32'(obi_rid_o), 32'(v.aid));
        obi_rready_i = 1'b1;
        nextCycle();
        obi_rready_i = 1'b0;
        #1;
        checkOutput($sformatf("v%0d idle rvalid", idx), 32'(obi_rvalid_o), 32'd0);
    endtask

    // Main sequence: reset, vector table, then hand-written corner cases.
    initial begin
        vector_t v;

        //            we    addr          be     wdata         aid  wt    to    prdata        slv   exp_rdata     err   strb
        vectors[0] = '{1'b0, 32'h0000_1004, 4'hF, 32'h0,        1'b1, 4'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'h0};
        vectors[1] = '{1'b1, 32'h0000_2008, 4'h3, 32'h1234_5678, 1'b0, 4'd3, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b0, 4'h3};
        vectors[2] = '{1'b0, 32'h0000_3000, 4'hF, 32'h0,        1'b0, 4'd1, 1'b0, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1, 4'h0};
        vectors[3] = '{1'b0, 32'h0000_4000, 4'hF, 32'h0,        1'b1, 4'd0, 1'b1, 32'h5555_5555, 1'b0, 32'h0,        1'b1, 4'h0};
        vectors[4] = '{1'b1, 32'h0000_400C, 4'hF, 32'hCAFE_0001, 1'b1, 4'd0, 1'b0, 32'h7777_7777, 1'b1, 32'h0,        1'b1, 4'hF};

        rst_i        = 1'b1;
        obi_req_i    = 1'b0;
        obi_addr_i   = 32'h0;
        obi_we_i     = 1'b0;
        obi_be_i     = 4'h0;
        obi_wdata_i  = 32'h0;
        obi_aid_i    = 1'b0;
        obi_rready_i = 1'b0;
        pready_i     = 1'b0;
        prdata_i     = 32'h0;
        pslverr_i    = 1'b0;
        nextCycle();
        nextCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("reset psel", 32'(psel_o), 32'd0);
        checkOutput("reset penable", 32'(penable_o), 32'd0);
        checkOutput("reset rvalid", 32'(obi_rvalid_o), 32'd0);
        checkOutput("reset err", 32'(obi_err_o), 32'd0);
        checkOutput("reset paddr", paddr_o, 32'h0);
        checkOutput("reset gnt", 32'(obi_gnt_o), 32'd0);
        checkOutput("pprot", 32'(pprot_o), 32'd0);
        nextCycle();

        for (int i = 0; i < 5; i++) begin
            runTransaction(vectors[i], i);
        end

        // Back-pressure: the response is held for 5 cycles while a second
        // request waits; the second grant may only appear once back in IDLE.
        v = vectors[0];
        v.addr = 32'h0000_5000;
        applyStimulus(v, 1'b1);
        #1;
        checkOutput("bp gnt1", 32'(obi_gnt_o), 32'd1);
        nextCycle();
        obi_addr_i = 32'h0000_6000;
        obi_aid_i  = 1'b0;
        #1;
        checkOutput("bp setup gnt", 32'(obi_gnt_o), 32'd0);
        nextCycle();
        pready_i = 1'b1;
        prdata_i = 32'hCAFE_F00D;
        #1;
        checkOutput("bp access gnt", 32'(obi_gnt_o), 32'd0);
        nextCycle();
        pready_i = 1'b0;
        prdata_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp hold%0d rvalid", i), 32'(obi_rvalid_o), 32'd1);
            checkOutput($sformatf("bp hold%0d rdata", i), obi_rdata_o, 32'hCAFE_F00D);
            checkOutput($sformatf("bp hold%0d rid", i), 32'(obi_rid_o), 32'd1);
            checkOutput($sformatf("bp hold%0d gnt", i), 32'(obi_gnt_o), 32'd0);
            nextCycle();
        end
        obi_rready_i = 1'b1;
        #1;
        checkOutput("bp release gnt", 32'(obi_gnt_o), 32'd0);
        nextCycle();
        obi_rready_i = 1'b0;
        #1;
        checkOutput("bp idle rvalid", 32'(obi_rvalid_o), 32'd0);
        checkOutput("bp gnt2", 32'(obi_gnt_o), 32'd1);
        nextCycle();
        obi_req_i = 1'b0;
        #1;
        checkOutput("bp2 paddr", paddr_o, 32'h0000_6000);
        checkOutput("bp2 psel", 32'(psel_o), 32'd1);
        nextCycle();
        pready_i = 1'b1;
        prdata_i = 32'h0000_0011;
        nextCycle();
        pready_i = 1'b0;
        #1;
        checkOutput("bp2 rvalid", 32'(obi_rvalid_o), 32'd1);
        checkOutput("bp2 rdata", obi_rdata_o, 32'h0000_0011);
        checkOutput("bp2 rid", 32'(obi_rid_o), 32'd0);
        obi_rready_i = 1'b1;
        nextCycle();
        obi_rready_i = 1'b0;

        // Reset in the middle of a stalled ACCESS phase: the transfer is
        // dropped and no response appears afterwards.
        v = vectors[1];
        v.addr = 32'h0000_7000;
        applyStimulus(v, 1'b1);
        nextCycle();
        obi_req_i = 1'b0;
        nextCycle();
        #1;
        checkOutput("rst-mid penable before", 32'(penable_o), 32'd1);
        nextCycle();
        rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        #1;
        checkOutput("rst-mid psel", 32'(psel_o), 32'd0);
        checkOutput("rst-mid penable", 32'(penable_o), 32'd0);
        checkOutput("rst-mid rvalid", 32'(obi_rvalid_o), 32'd0);
        checkOutput("rst-mid paddr", paddr_o, 32'h0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            #1;
            checkOutput($sformatf("rst-mid quiet%0d rvalid", i), 32'(obi_rvalid_o), 32'd0);
        end
        nextCycle();
        runTransaction(vectors[0], 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
